// File: rtl/madd_sweep_ctrl.sv
// Exhaustive sweep controller for a 6-input approximate multiply-add circuit:
// drives all 64 vectors, compares against a*b+c and reports worst-case error stats.
module madd_sweep_ctrl #(
  parameter int unsigned ET = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] dut_in,
  input  logic [3:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       pass,
  output logic [3:0] max_err,
  output logic [5:0] worst_vec,
  output logic [6:0] viol_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [4:0] ET_C = 5'(ET);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       pv_q, pv_d;
  logic [4:0] perr_q, perr_d;
  logic [5:0] pvec_q, pvec_d;
  logic [3:0] max_q, max_d;
  logic [5:0] worst_q, worst_d;
  logic [6:0] viol_q, viol_d;
  logic       pass_q, pass_d;
  logic       aborted_q, aborted_d;
  logic [5:0] vec_s;
  logic [4:0] exact_s;
  logic [4:0] err_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in IDLE, where it also beats abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SWEEP : IDLE;
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd63) begin
          state_d = DRAIN;
        end else begin
          state_d = SWEEP;
        end
      end
      DRAIN:   state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy   = (state_q == SWEEP) || (state_q == DRAIN);
    done   = (state_q == DONE);
    vec_s  = (state_q == SWEEP) ? cnt_q : 6'd0;
    dut_in = vec_s;
  end

  // Exact reference and absolute error of the vector currently driven
  always_comb begin
    exact_s = ({3'd0, vec_s[1:0]} * {3'd0, vec_s[3:2]}) + {3'd0, vec_s[5:4]};
    if (exact_s >= {1'b0, dut_out}) begin
      err_s = exact_s - {1'b0, dut_out};
    end else begin
      err_s = {1'b0, dut_out} - exact_s;
    end
  end

  // Counter, error pipeline and accumulator next-state
  always_comb begin
    cnt_d     = cnt_q;
    pv_d      = 1'b0;
    perr_d    = perr_q;
    pvec_d    = pvec_q;
    max_d     = max_q;
    worst_d   = worst_q;
    viol_d    = viol_q;
    pass_d    = pass_q;
    aborted_d = aborted_q;
    if ((state_q == IDLE) && start) begin
      cnt_d     = 6'd0;
      max_d     = 4'd0;
      worst_d   = 6'd0;
      viol_d    = 7'd0;
      pass_d    = 1'b0;
      aborted_d = 1'b0;
    end else begin
      // A pending registered error is folded in even on the abort edge
      if (pv_q) begin
        if (perr_q > {1'b0, max_q}) begin
          max_d   = perr_q[3:0];
          worst_d = pvec_q;
        end else begin
          max_d   = max_q;
        end
        if (perr_q > ET_C) begin
          viol_d = viol_q + 7'd1;
        end else begin
          viol_d = viol_q;
        end
      end else begin
        max_d = max_q;
      end
      if ((state_q == SWEEP) && !abort) begin
        pv_d   = 1'b1;
        perr_d = err_s;
        pvec_d = vec_s;
        cnt_d  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
      end else begin
        pv_d = 1'b0;
      end
      if (busy && abort) begin
        aborted_d = 1'b1;
      end else if ((state_q == DRAIN) && !abort) begin
        pass_d = ({1'b0, max_d} <= ET_C);
      end else begin
        aborted_d = aborted_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 6'd0;
      pv_q      <= 1'b0;
      perr_q    <= 5'd0;
      pvec_q    <= 6'd0;
      max_q     <= 4'd0;
      worst_q   <= 6'd0;
      viol_q    <= 7'd0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pv_q      <= pv_d;
      perr_q    <= perr_d;
      pvec_q    <= pvec_d;
      max_q     <= max_d;
      worst_q   <= worst_d;
      viol_q    <= viol_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
    end
  end

  assign max_err   = max_q;
  assign worst_vec = worst_q;
  assign viol_cnt  = viol_q;
  assign pass      = pass_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_madd_sweep_ctrl.sv
// Scoreboard bench for madd_sweep_ctrl: a behavioural approximate circuit answers
// dut_in, expected sweep results are queued at start and compared on done.
module tb_madd_sweep_ctrl;
  localparam int ET = 6;

  typedef struct {
    int max_err;
    int worst;
    int viol;
    int pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [5:0] dut_in;
  logic [3:0] dut_out;
  logic       busy, done, aborted, pass;
  logic [3:0] max_err;
  logic [5:0] worst_vec;
  logic [6:0] viol_cnt;

  int   n_vec = 0;
  int   n_mis = 0;
  int   mode  = 0;
  exp_t sb_q[$];

  madd_sweep_ctrl #(.ET(ET)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .aborted(aborted), .pass(pass),
    .max_err(max_err), .worst_vec(worst_vec), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  function automatic int exact_of(int v);
    return (v & 3) * ((v >> 2) & 3) + ((v >> 4) & 3);
  endfunction

  // mode 0 exact, 1 stuck at 0, 2 stuck at 15, 3 exact with bits 3/0 flipped
  function automatic int model_out(int m, int v);
    int ex;
    ex = exact_of(v);
    case (m)
      0:       return ex;
      1:       return 0;
      2:       return 15;
      default: return (ex ^ ((((v >> 5) & 1) << 3) | (v & 1))) & 15;
    endcase
  endfunction

  function automatic exp_t model_run(int m, int last);
    exp_t e;
    int   ex, o, er;
    e = '{0, 0, 0, 0};
    for (int v = 0; v <= last; v++) begin
      ex = exact_of(v);
      o  = model_out(m, v);
      er = (ex > o) ? ex - o : o - ex;
      if (er > e.max_err) begin
        e.max_err = er;
        e.worst   = v;
      end
      if (er > ET) e.viol++;
    end
    e.pass = (e.max_err <= ET) ? 1 : 0;
    return e;
  endfunction

  always_comb dut_out = 4'(model_out(mode, int'(dut_in)));

  task automatic check(string tag, int obs, int exp);
    n_vec++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Full sweep; optional immediate start, re-pulse of start mid-sweep, abort alongside start
  task automatic run_full(int m, bit now, bit restart_mid, bit abort_with_start);
    exp_t e, got;
    int   done_at, done_cnt;
    mode = m;
    e = model_run(m, 63);
    sb_q.push_back(e);
    if (!now) @(negedge clk);
    start = 1'b1;
    abort = abort_with_start;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    done_at  = 0;
    done_cnt = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 64) check("dut_in", int'(dut_in), c - 1);
      if (c == 1) begin
        check("busy_first", int'(busy), 1);
        check("aborted_clr", int'(aborted), 0);
        check("viol_clr", int'(viol_cnt), 0);
      end
      if (c == 65) check("busy_drain", int'(busy), 1);
      if (c == 67) check("busy_idle", int'(busy), 0);
      if (c == 67) check("dut_in_idle", int'(dut_in), 0);
      if (restart_mid) start = (c == 20);
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c;
          if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
          end else begin
            got = sb_q.pop_front();
            check("max_err", int'(max_err), got.max_err);
            check("worst_vec", int'(worst_vec), got.worst);
            check("viol_cnt", int'(viol_cnt), got.viol);
            check("pass", int'(pass), got.pass);
          end
        end
      end
    end
    start = 1'b0;
    check("done_cycle", done_at, 66);
    check("done_count", done_cnt, 1);
    check("hold_max_err", int'(max_err), e.max_err);
    check("hold_viol", int'(viol_cnt), e.viol);
    check("hold_pass", int'(pass), e.pass);
  endtask

  task automatic abort_test();
    exp_t e;
    int   dn;
    bit   hit;
    mode = 2;
    e = model_run(2, 9);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 1; c <= 20 && !hit; c++) begin
      if (c > 1) @(negedge clk);
      if (int'(dut_in) == 10) hit = 1'b1;
    end
    check("abort_reached_10", int'(hit), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_flag", int'(aborted), 1);
    check("abort_viol", int'(viol_cnt), e.viol);
    check("abort_max", int'(max_err), e.max_err);
    check("abort_worst", int'(worst_vec), e.worst);
    check("abort_dut_in", int'(dut_in), 0);
    dn = 0;
    for (int c = 0; c < 70; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    check("abort_pass", int'(pass), 0);
    check("abort_hold", int'(aborted), 1);
    check("abort_hold_viol", int'(viol_cnt), e.viol);
  endtask

  task automatic reset_test();
    bit hit;
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 1; c <= 40 && !hit; c++) begin
      if (c > 1) @(negedge clk);
      if (int'(dut_in) == 30) hit = 1'b1;
    end
    check("rst_reached_30", int'(hit), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_max", int'(max_err), 0);
    check("rst_worst", int'(worst_vec), 0);
    check("rst_viol", int'(viol_cnt), 0);
    check("rst_dut_in", int'(dut_in), 0);
    #1 rst = 1'b0;
    run_full(3, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_max", int'(max_err), 0);
    check("reset_viol", int'(viol_cnt), 0);
    check("reset_dut_in", int'(dut_in), 0);
    rst = 1'b0;
    run_full(0, 1'b1, 1'b0, 1'b0);
    run_full(1, 1'b0, 1'b1, 1'b0);
    run_full(2, 1'b0, 1'b0, 1'b1);
    run_full(3, 1'b0, 1'b0, 1'b0);
    abort_test();
    reset_test();
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
